// File: rtl/gshare_predictor.sv
// Direction predictor: table of saturating counters indexed by PC (bimodal) or
// PC ^ GHR (gshare). Combinational lookup at fetch, training and GHR repair at MEM.
module gshare_predictor #(
    parameter int IDX_BITS  = 6,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 6,
    parameter int MODE      = 1,
    parameter int PERF_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          PC_IF,
    input  logic                 fetch_valid,
    output logic                 Predict_Taken,
    output logic [HIST_BITS-1:0] Predict_GHR,
    input  logic [31:0]          PC_MEM,
    input  logic                 is_Branch_MEM,
    input  logic                 Actual_Taken,
    input  logic [HIST_BITS-1:0] GHR_MEM,
    input  logic                 Mispredict_MEM,
    output logic [PERF_BITS-1:0] perf_branches,
    output logic [PERF_BITS-1:0] perf_mispred
);
    localparam int                ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
    logic [CTR_BITS-1:0]  ctr_wr_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [PERF_BITS-1:0] perf_br_q, perf_br_d;
    logic [PERF_BITS-1:0] perf_mp_q, perf_mp_d;
    logic [IDX_BITS-1:0]  ridx, widx;
    logic                 mispred;

    // Only the word-aligned index bits of either PC participate in lookup.
    logic unused_pc;
    assign unused_pc = ^{PC_IF[31:IDX_BITS+2], PC_IF[1:0], PC_MEM[31:IDX_BITS+2], PC_MEM[1:0]};

    assign mispred = is_Branch_MEM && Mispredict_MEM;

    always_comb begin
        ridx = PC_IF[IDX_BITS+1:2]  ^ ((MODE != 0) ? IDX_BITS'(ghr_q)   : '0);
        widx = PC_MEM[IDX_BITS+1:2] ^ ((MODE != 0) ? IDX_BITS'(GHR_MEM) : '0);
    end

    assign Predict_Taken = ctr_q[ridx][CTR_BITS-1];
    assign Predict_GHR   = ghr_q;
    assign perf_branches = perf_br_q;
    assign perf_mispred  = perf_mp_q;

    always_comb begin
        ctr_wr_d = ctr_q[widx];
        if (Actual_Taken) begin
            if (ctr_q[widx] != CTR_MAX) ctr_wr_d = ctr_q[widx] + 1'b1;
        end else begin
            if (ctr_q[widx] != '0) ctr_wr_d = ctr_q[widx] - 1'b1;
        end
    end

    // Repair from the fetch-time snapshot beats the speculative shift; the cast
    // drops the oldest bit and also covers a single-bit history.
    always_comb begin
        ghr_d = ghr_q;
        if (mispred)
            ghr_d = HIST_BITS'({GHR_MEM, Actual_Taken});
        else if (fetch_valid)
            ghr_d = HIST_BITS'({ghr_q, Predict_Taken});
    end

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (is_Branch_MEM && (perf_br_q != '1)) perf_br_d = perf_br_q + 1'b1;
        if (mispred && (perf_mp_q != '1))       perf_mp_d = perf_mp_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
        end else if (is_Branch_MEM) begin
            ctr_q[widx] <= ctr_wr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q     <= '0;
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

endmodule
